// File: rtl/gol_gen_scheduler.sv
// Game of Life generation scheduler: tick/step pacing, cell-index sweep, commit pulse and edit arbitration.
// Optional stable-grid detection is compiled in when GOL_STABLE_DETECT_EN is defined.
module gol_gen_scheduler #(
  parameter int GRID_SIZE = 16,
  parameter int TICK_DIV  = 25000000,
  parameter int IDX_W     = $clog2(GRID_SIZE*GRID_SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  input  logic             edit_req,
  output logic             edit_gnt,
  output logic             eng_valid,
  output logic [IDX_W-1:0] eng_idx,
  input  logic             eng_ready,
  input  logic             eng_changed,
  output logic             commit,
  output logic             busy,
  output logic [15:0]      gen_count,
  output logic             stable
);
  localparam int                 CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]   TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(GRID_SIZE*GRID_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_COMMIT} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_pending;
  logic               r_gnt;
  logic               r_valid;
  logic [IDX_W-1:0]   r_idx;
  logic               r_commit;
  logic               r_busy;
  logic [15:0]        r_gen_count;

  logic               w_idle;
  logic               w_start;
  logic               w_accept;
  logic               w_last;
  logic               w_tick;
  logic               w_suppress;

  assign w_idle   = (r_state == S_IDLE);
  // Edits own the write path: no generation may start while a request or grant is live.
  assign w_start  = w_idle & r_pending & ~edit_req & ~r_gnt;
  assign w_accept = r_valid & eng_ready;
  assign w_last   = w_accept & (r_idx == LAST_IDX);
  assign w_tick   = w_idle & run & ~w_suppress & (r_cnt == TICK_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_state_nxt = S_SWEEP;
      S_SWEEP:  if (w_last)  w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pending   <= 1'b0;
      r_gnt       <= 1'b0;
      r_valid     <= 1'b0;
      r_idx       <= '0;
      r_commit    <= 1'b0;
      r_busy      <= 1'b0;
      r_gen_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_idle & edit_req;

      // Counter is frozen at zero for the whole generation, so ticks never queue up.
      if (!w_idle || w_start || w_suppress || w_tick) begin
        r_cnt <= '0;
      end else if (run) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_start) begin
        r_pending <= 1'b0;
      end else if (w_tick || (w_idle && !run && step)) begin
        r_pending <= 1'b1;
      end

      r_commit <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_valid <= 1'b1;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_SWEEP: begin
          if (w_last) begin
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_commit <= 1'b1;
          end else if (w_accept) begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_COMMIT: begin
          r_busy      <= 1'b0;
          r_gen_count <= r_gen_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef GOL_STABLE_DETECT_EN
  logic r_any_change;
  logic r_stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_any_change <= 1'b0;
      r_stable     <= 1'b0;
    end else begin
      if (w_start) begin
        r_any_change <= 1'b0;
      end else if (w_accept && eng_changed) begin
        r_any_change <= 1'b1;
      end
      // A fresh edit may make the grid evolve again, so it re-arms automatic ticks.
      if (r_state == S_COMMIT) begin
        r_stable <= ~r_any_change;
      end else if (w_idle && edit_req && !r_gnt) begin
        r_stable <= 1'b0;
      end
    end
  end

  assign w_suppress = r_stable;
  assign stable     = r_stable;
`else
  logic w_unused_changed;
  assign w_unused_changed = eng_changed;
  assign w_suppress       = 1'b0;
  assign stable           = 1'b0;
`endif

  assign edit_gnt  = r_gnt;
  assign eng_valid = r_valid;
  assign eng_idx   = r_idx;
  assign commit    = r_commit;
  assign busy      = r_busy;
  assign gen_count = r_gen_count;

endmodule

// File: tb/tb_gol_gen_scheduler.sv
// Scoreboard bench for gol_gen_scheduler: expected index/commit streams are queued by the stimulus
// and consumed by an independent negedge monitor.
`timescale 1ns/1ps
module tb_gol_gen_scheduler;
  localparam int GS = 4;
  localparam int TD = 4;
  localparam int N  = GS*GS;
  localparam int IW = $clog2(N);
`ifdef GOL_STABLE_DETECT_EN
  localparam bit STABLE_EN = 1'b1;
`else
  localparam bit STABLE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic          edit_req = 1'b0;
  logic          eng_ready = 1'b1;
  logic          eng_changed = 1'b1;
  logic          edit_gnt;
  logic          eng_valid;
  logic [IW-1:0] eng_idx;
  logic          commit;
  logic          busy;
  logic [15:0]   gen_count;
  logic          stable;

  int n_chk  = 0;
  int n_fail = 0;
  int idx_q[$];
  int gc_q[$];
  int model_gc = 0;
  int rmode = 0;
  int rphase = 0;
  int chg_mode = 1;
  bit any_chg = 1'b0;

  gol_gen_scheduler #(.GRID_SIZE(GS), .TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step),
    .edit_req(edit_req), .edit_gnt(edit_gnt),
    .eng_valid(eng_valid), .eng_idx(eng_idx), .eng_ready(eng_ready),
    .eng_changed(eng_changed), .commit(commit), .busy(busy),
    .gen_count(gen_count), .stable(stable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One generation as seen from outside: indices 0..N-1 in order, then one commit.
  task automatic expect_gen();
    for (int i = 0; i < N; i++) idx_q.push_back(i);
    idx_q.push_back(-1);
    model_gc = (model_gc + 1) % 65536;
    gc_q.push_back(model_gc);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step_pulse();
    step = 1'b1;
    cycles(1);
    step = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    do begin
      cycles(1);
      n++;
    end while (!eng_valid && n < 300);
    if (!eng_valid) chk({name, "_valid_timeout"}, int'(eng_valid), 1);
  endtask

  task automatic wait_idle(input string name, output int n);
    n = 0;
    do begin
      cycles(1);
      n++;
    end while (busy && n < 2000);
    chk({name, "_idle"}, int'(busy), 0);
  endtask

  // eng_ready / eng_changed drivers
  initial forever begin
    @(posedge clk);
    #1;
    case (rmode)
      1: begin
        eng_ready = (rphase == 0 || rphase == 3);
        rphase = (rphase + 1) % 4;
      end
      2:       eng_ready = ($urandom_range(0, 2) != 0);
      default: eng_ready = 1'b1;
    endcase
    case (chg_mode)
      0:       eng_changed = 1'b0;
      2:       eng_changed = ($urandom_range(0, 3) == 0);
      default: eng_changed = 1'b1;
    endcase
  end

  // Monitor
  initial begin : monitor
    bit gc_chk;
    int gc_exp;
    bit st_chk;
    bit st_exp;
    gc_chk = 1'b0;
    gc_exp = 0;
    st_chk = 1'b0;
    st_exp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (gc_chk) begin
          chk("gen_count", int'(gen_count), gc_exp);
          gc_chk = 1'b0;
        end
        if (st_chk) begin
          chk("stable_after_commit", int'(stable), int'(st_exp));
          st_chk = 1'b0;
        end
        chk("busy_vs_activity", int'(busy), int'(eng_valid | commit));
        chk("gnt_while_busy", int'(edit_gnt & busy), 0);
        if (eng_valid) begin
          if (idx_q.size() == 0 || idx_q[0] < 0) begin
            chk("spurious_valid", int'(eng_valid), 0);
          end else begin
            chk("eng_idx", int'(eng_idx), idx_q[0]);
            if (eng_ready) begin
              void'(idx_q.pop_front());
              if (eng_changed) any_chg = 1'b1;
            end
          end
        end else begin
          chk("idx_zero_when_invalid", int'(eng_idx), 0);
        end
        if (commit) begin
          if (idx_q.size() > 0 && idx_q[0] == -1 && gc_q.size() > 0) begin
            void'(idx_q.pop_front());
            gc_exp = gc_q.pop_front();
            gc_chk = 1'b1;
            st_exp = STABLE_EN & !any_chg;
            st_chk = 1'b1;
            any_chg = 1'b0;
          end else begin
            chk("spurious_commit", int'(commit), 0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    int k;
    int t;
    cycles(2);
    chk("rst_valid", int'(eng_valid), 0);
    chk("rst_idx", int'(eng_idx), 0);
    chk("rst_commit", int'(commit), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_gnt", int'(edit_gnt), 0);
    chk("rst_gen_count", int'(gen_count), 0);
    chk("rst_stable", int'(stable), 0);
    rst_n = 1'b1;
    cycles(1);

    // Auto-run: first tick after TD cycles, sweep N+1 cycles, restart TD+1 after idle
    expect_gen();
    expect_gen();
    run = 1'b1;
    wait_valid("auto1", n);
    chk("auto_first_start", n, TD + 1);
    wait_idle("auto1", n);
    chk("auto_sweep_len", n, N + 1);
    wait_valid("auto2", n);
    chk("auto_restart", n, TD + 1);
    run = 1'b0;
    wait_idle("auto2", n);
    cycles(3 * TD);
    chk("auto_drained", idx_q.size(), 0);

    // Backpressure 1,0,0,1 with a step issued mid-sweep that must be ignored
    rmode = 1;
    expect_gen();
    step_pulse();
    wait_valid("bp", n);
    chk("step_latency", n, 1);
    cycles(5);
    step_pulse();
    wait_idle("bp", n);
    cycles(3 * TD);
    chk("bp_drained", idx_q.size(), 0);
    rmode = 0;

    // step while run=1 is ignored: start comes from the tick
    expect_gen();
    run = 1'b1;
    step = 1'b1;
    cycles(1);
    step = 1'b0;
    wait_valid("step_run", n);
    chk("step_run_ignored", n, TD);
    run = 1'b0;
    wait_idle("step_run", n);
    cycles(2 * TD);
    chk("step_run_drained", idx_q.size(), 0);

    // Edit held across ticks blocks generations; release starts sweep 2 cycles later
    edit_req = 1'b1;
    run = 1'b1;
    cycles(1);
    chk("gnt_follows_req", int'(edit_gnt), 1);
    cycles(3 * TD);
    chk("gnt_held", int'(edit_gnt), 1);
    chk("no_sweep_during_edit", int'(busy), 0);
    expect_gen();
    edit_req = 1'b0;
    run = 1'b0;
    cycles(1);
    chk("gnt_drop", int'(edit_gnt), 0);
    wait_valid("edit_release", n);
    chk("start_after_edit", n, 1);
    wait_idle("edit_release", n);

    // Edit raised mid-sweep waits until after commit
    expect_gen();
    step_pulse();
    wait_valid("edit_mid", n);
    cycles(3);
    edit_req = 1'b1;
    cycles(2);
    chk("gnt_blocked_sweep", int'(edit_gnt), 0);
    wait_idle("edit_mid", n);
    chk("gnt_at_idle_entry", int'(edit_gnt), 0);
    cycles(1);
    chk("gnt_after_commit", int'(edit_gnt), 1);
    edit_req = 1'b0;
    cycles(2);
    chk("edit_mid_drained", idx_q.size(), 0);

    // Randomized: random ready/changed, edits around steps, ignored steps mid-sweep
    rmode = 2;
    chg_mode = 2;
    for (int g = 0; g < 12; g++) begin
      k = int'($urandom_range(0, 4));
      if (k > 0) begin
        edit_req = 1'b1;
        cycles(k);
      end
      expect_gen();
      step_pulse();
      if (k > 0) begin
        cycles(int'($urandom_range(0, 3)));
        edit_req = 1'b0;
      end
      wait_valid("rand", n);
      cycles(int'($urandom_range(1, 10)));
      if ($urandom_range(0, 1) == 1) step_pulse();
      wait_idle("rand", n);
      cycles(int'($urandom_range(0, 6)));
    end
    cycles(10);
    chk("rand_drained", idx_q.size(), 0);
    rmode = 0;
    chg_mode = 1;

`ifdef GOL_STABLE_DETECT_EN
    chg_mode = 0;
    expect_gen();
    step_pulse();
    wait_valid("stable_gen", n);
    wait_idle("stable_gen", n);
    cycles(1);
    chk("stable_set", int'(stable), 1);
    run = 1'b1;
    cycles(6 * TD);
    chk("stable_suppresses_tick", int'(busy), 0);
    run = 1'b0;
    chg_mode = 1;
    expect_gen();
    step_pulse();
    wait_valid("stable_step", n);
    wait_idle("stable_step", n);
    cycles(1);
    chk("stable_cleared", int'(stable), 0);
`else
    chg_mode = 0;
    expect_gen();
    run = 1'b1;
    wait_valid("nostable", n);
    run = 1'b0;
    wait_idle("nostable", n);
    cycles(1);
    chk("stable_tied_low", int'(stable), 0);
    chg_mode = 1;
`endif
    cycles(2);
    chk("pre_reset_drained", idx_q.size(), 0);

    // Reset mid-sweep: async clear, no commit, idle afterwards
    expect_gen();
    step_pulse();
    wait_valid("rst_mid", n);
    t = 0;
    while (int'(eng_idx) != 10 && t < 100) begin
      cycles(1);
      t++;
    end
    chk("rst_mid_at_idx", int'(eng_idx), 10);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(eng_valid), 0);
    chk("arst_idx", int'(eng_idx), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_commit", int'(commit), 0);
    chk("arst_gen_count", int'(gen_count), 0);
    idx_q.delete();
    gc_q.delete();
    model_gc = 0;
    any_chg = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(3 * TD);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_valid", int'(eng_valid), 0);
    chk("post_rst_gen_count", int'(gen_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
